// File: rtl/camera_pattern_source.sv
// camera_pattern_source: transmit side of an 8-bit parallel camera link.
// Emits timed frames (v_sync / blank / active / blank) carrying a synthetic
// pattern. There are two bytes per pixel and one byte per pclk period. pclk
// is a registered divide-by-2 of clk_25.
module camera_pattern_source #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       clk_25,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] fill,
  output logic       pclk,
  output logic [7:0] data_out,
  output logic       h_ref,
  output logic       v_sync,
  output logic       busy,
  output logic       frame_done
);

  localparam int LB   = 2 * (H_ACTIVE + H_BLANK);
  localparam int BW   = $clog2(LB);
  localparam int LM0  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int LM1  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int LMAX = (LM0 > LM1) ? LM0 : LM1;
  localparam int LW   = (LMAX > 1) ? $clog2(LMAX) : 1;

  localparam logic [BW-1:0] B_LAST = BW'(LB - 1);
  localparam logic [BW-1:0] B_ACT  = BW'(2 * H_ACTIVE);

  // Zero-sized timing fields make no sense; refuse to elaborate.
  generate
    if (H_ACTIVE == 0 || H_BLANK == 0 || V_ACTIVE == 0 ||
        VSYNC_LINES == 0 || V_BACK == 0 || V_FRONT == 0) begin : g_bad_param
      $error("camera_pattern_source: all timing parameters must be non-zero");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
  } state_t;

  state_t          state;
  logic [BW-1:0]   bcnt;
  logic [LW-1:0]   lcnt;
  logic [1:0]      mode_q;
  logic [7:0]      fill_q;

  logic [7:0]      col8, row8, pat;
  logic            hr_nxt, vs_nxt;

  // Index of the last line in each timed state.
  function automatic logic [LW-1:0] last_line(input state_t s);
    case (s)
      S_VSYNC:  return LW'(VSYNC_LINES - 1);
      S_VBACK:  return LW'(V_BACK - 1);
      S_ACTIVE: return LW'(V_ACTIVE - 1);
      S_VFRONT: return LW'(V_FRONT - 1);
      default:  return '0;
    endcase
  endfunction

  // Pattern byte and sync levels for the slot the counters point at.
  // In ACTIVE the line counter is the row index.
  always_comb begin
    col8   = 8'(bcnt[BW-1:1]);
    row8   = 8'(lcnt);
    hr_nxt = (state == S_ACTIVE) && (bcnt < B_ACT);
    vs_nxt = (state == S_VSYNC);
    pat    = 8'h00;
    case (mode_q)
      2'b00:   pat = fill_q;
      2'b01:   pat = bcnt[0] ? row8 : col8;
      2'b10:   pat = {col8[7:6], 6'b0};
      default: pat = (col8[3] ^ row8[3]) ? 8'hFF : 8'h00;
    endcase
  end

  // Frame sequencer: outputs move on pclk falling, counters on pclk rising.
  // The last slot's rising edge is kept after the frame ends; IDLE with pclk=1
  // is that trailing half-period, after which pclk parks low.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      bcnt       <= '0;
      lcnt       <= '0;
      mode_q     <= 2'b00;
      fill_q     <= 8'h00;
      pclk       <= 1'b0;
      data_out   <= 8'h00;
      h_ref      <= 1'b0;
      v_sync     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE) begin
        if (pclk) begin
          pclk     <= 1'b0;
          busy     <= 1'b0;
          data_out <= 8'h00;
          h_ref    <= 1'b0;
          v_sync   <= 1'b0;
        end else if (enable) begin
          state  <= S_VSYNC;
          pclk   <= 1'b1;
          busy   <= 1'b1;
          bcnt   <= '0;
          lcnt   <= '0;
          mode_q <= mode;
          fill_q <= fill;
        end
      end else begin
        pclk <= ~pclk;
        if (pclk) begin
          data_out <= hr_nxt ? pat : 8'h00;
          h_ref    <= hr_nxt;
          v_sync   <= vs_nxt;
        end else if (bcnt != B_LAST) begin
          bcnt <= bcnt + 1'b1;
        end else begin
          bcnt <= '0;
          if (lcnt != last_line(state)) begin
            lcnt <= lcnt + 1'b1;
          end else begin
            lcnt <= '0;
            case (state)
              S_VSYNC:  state <= S_VBACK;
              S_VBACK:  state <= S_ACTIVE;
              S_ACTIVE: state <= S_VFRONT;
              default: begin
                frame_done <= 1'b1;
                if (enable) begin
                  state  <= S_VSYNC;
                  mode_q <= mode;
                  fill_q <= fill;
                end else begin
                  state <= S_IDLE;
                end
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_pattern_source.sv
// tb_camera_pattern_source: cycle-by-cycle comparison of the pattern source
// against a frame model that maps "cycles since frame start" to the expected
// slot, plus scripted and randomized enable/mode/fill/reset activity.
module tb_camera_pattern_source;

  localparam int HA = 4, HB = 2, VA = 3, VS = 1, VB = 1, VF = 1;
  localparam int LBS   = 2 * (HA + HB);
  localparam int NSLOT = LBS * (VS + VB + VA + VF);

  logic       clk_25 = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] fill = 8'h00;
  logic       pclk, h_ref, v_sync, busy, frame_done;
  logic [7:0] data_out;

  int n_chk  = 0;
  int n_pass = 0;

  camera_pattern_source #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk_25(clk_25), .reset_n(reset_n), .enable(enable), .mode(mode),
    .fill(fill), .pclk(pclk), .data_out(data_out), .h_ref(h_ref),
    .v_sync(v_sync), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk_25 = ~clk_25;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected {v_sync, h_ref, data} of frame slot s, straight from the frame layout.
  function automatic logic [9:0] slot_exp(input int s, input logic [1:0] md, input logic [7:0] fl);
    int line, b, row, col;
    logic [7:0] d;
    line = s / LBS;
    b    = s % LBS;
    if (line < VS) return {1'b1, 1'b0, 8'h00};
    if (line < VS + VB || line >= VS + VB + VA || b >= 2 * HA) return 10'h000;
    row = line - VS - VB;
    col = b / 2;
    case (md)
      2'd0:    d = fl;
      2'd1:    d = (b % 2 == 0) ? 8'(col % 256) : 8'(row % 256);
      2'd2:    d = 8'(((col % 256) / 64) * 64);
      default: d = (((col / 8) + (row / 8)) % 2 == 1) ? 8'hFF : 8'h00;
    endcase
    return {1'b0, 1'b1, d};
  endfunction

  // Reference model and per-cycle comparison, sampled 1 time unit after each edge.
  initial begin : monitor
    bit         run, trail, p_rst;
    int         j;
    logic [1:0] md;
    logic [7:0] fl;
    logic       e_pclk, e_busy, e_fd, p_pclk, p_href, p_vs;
    logic [9:0] e_out;
    logic [7:0] p_data;
    run = 0; trail = 0; p_rst = 0; j = 0; md = 2'b00; fl = 8'h00;
    p_pclk = 0; p_href = 0; p_vs = 0; p_data = 8'h00;
    forever begin
      @(posedge clk_25);
      e_fd = 1'b0;
      if (!reset_n) begin
        run = 0; trail = 0;
      end else if (trail) begin
        trail = 0;
      end else if (!run) begin
        if (enable) begin run = 1; j = 0; md = mode; fl = fill; end
      end else begin
        j++;
        if (j == 2 * NSLOT) begin
          e_fd = 1'b1;
          if (enable) begin j = 0; md = mode; fl = fill; end
          else begin run = 0; trail = 1; end
        end
      end
      if (trail) begin
        e_pclk = 1'b1; e_busy = 1'b1; e_out = 10'h000;
      end else if (!run) begin
        e_pclk = 1'b0; e_busy = 1'b0; e_out = 10'h000;
      end else begin
        e_pclk = (j % 2 == 0);
        e_busy = 1'b1;
        e_out  = (j == 0) ? 10'h000 : slot_exp((j - 1) / 2, md, fl);
      end
      #1;
      chk("pclk", pclk, e_pclk);
      chk("busy", busy, e_busy);
      chk("frame_done", frame_done, e_fd);
      chk("v_sync", v_sync, e_out[9]);
      chk("h_ref", h_ref, e_out[8]);
      chk("data_out", data_out, e_out[7:0]);
      if (reset_n && p_rst) begin
        chk("href_vsync_excl", h_ref & v_sync, 1'b0);
        if ({data_out, h_ref, v_sync} != {p_data, p_href, p_vs})
          chk("chg_on_pclk_fall", {p_pclk, pclk}, 2'b10);
      end
      p_pclk = pclk; p_data = data_out; p_href = h_ref; p_vs = v_sync;
      p_rst  = reset_n;
    end
  end

  // Async reset pulse: outputs must clear before the next clock edge.
  task automatic reset_pulse();
    @(negedge clk_25);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_pclk", pclk, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_href", h_ref, 1'b0);
    chk("rst_vsync", v_sync, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fdone", frame_done, 1'b0);
    @(negedge clk_25);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    repeat (3) @(negedge clk_25);
    reset_n = 1'b1;
    // Frame 1: solid A5; switch to checker mid-frame (takes effect on frame 2).
    @(negedge clk_25);
    enable = 1'b1; mode = 2'b00; fill = 8'hA5;
    repeat (60) @(negedge clk_25);
    mode = 2'b11; fill = 8'($urandom);
    // Inside frame 2: request ramp for frame 3.
    repeat (200) @(negedge clk_25);
    mode = 2'b01;
    // Drop enable during ACTIVE row 1 of frame 3; frame completes then idles.
    repeat (110) @(negedge clk_25);
    enable = 1'b0;
    repeat (300) @(negedge clk_25);
    // Reset during ACTIVE with enable held: fresh frame from VSYNC.
    enable = 1'b1; mode = 2'b10; fill = 8'h00;
    repeat (100) @(negedge clk_25);
    reset_pulse();
    repeat (200) @(negedge clk_25);
    // Randomized activity.
    for (int it = 0; it < 8; it++) begin
      mode   = 2'($urandom);
      fill   = 8'($urandom);
      enable = 1'b1;
      repeat ($urandom_range(20, 400)) @(negedge clk_25);
      if ($urandom_range(0, 1) == 1) begin
        reset_pulse();
      end else begin
        enable = 1'b0;
        repeat ($urandom_range(150, 320)) @(negedge clk_25);
      end
    end
    enable = 1'b0;
    repeat (320) @(negedge clk_25);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
